// File: rtl/or5_event_resolver.sv
// Purpose: latch per-source event edges as sticky pending bits and dispatch them one at a time by fixed priority.
// Latency: event before edge k -> PEND/ANY after edge k, REQ/ID after edge k+1; one dispatch per 3 cycles max.
// Backpressure: REQ/ID held stable while RDY is low; new events keep accumulating in PEND meanwhile.
module or5_event_resolver #(
   parameter int N_SRC = 5,
   parameter int ID_W  = 3,
   parameter bit EDGE  = 1'b1
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [N_SRC-1:0] SRC,
   input  logic [N_SRC-1:0] MASK,
   input  logic             CLR_ALL,
   output logic [N_SRC-1:0] PEND,
   output logic             ANY,
   output logic             REQ,
   output logic [ID_W-1:0]  ID,
   input  logic             RDY
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OFFER = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [N_SRC-1:0] pend_q;
   logic [N_SRC-1:0] pend_d;
   logic [N_SRC-1:0] set_vec;
   logic [N_SRC-1:0] clr_vec;
   logic [ID_W-1:0]  id_q;
   logic [ID_W-1:0]  first_idx;
   logic             xfer;
   logic             load_id;

   // Capture: edge mode compares against last cycle's SRC; level mode re-sets while SRC is high.
   generate
      if (EDGE) begin : g_edge
         logic [N_SRC-1:0] src_q;

         // Delayed copy of SRC for rising-edge detection.
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               src_q <= '0;
            end else begin
               src_q <= SRC;
            end
         end

         assign set_vec = SRC & ~src_q & MASK;
      end else begin : g_level
         assign set_vec = SRC & MASK;
      end
   endgenerate

   // A transfer needs an active offer and ready; CLR_ALL suppresses it.
   assign xfer    = (state_q == S_OFFER) && RDY && !CLR_ALL;
   assign load_id = (state_q == S_IDLE) && (state_d == S_OFFER);

   // Lowest set pending bit wins; scanning downward leaves the lowest index last.
   always_comb begin
      first_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            first_idx = ID_W'(i);
         end
      end
   end

   // Clear vector: everything on CLR_ALL, else only the source just handed off.
   always_comb begin
      clr_vec = '0;
      if (CLR_ALL) begin
         clr_vec = '1;
      end else if (xfer) begin
         clr_vec = N_SRC'(1) << id_q;
      end
   end

   // Set has precedence over clear so an event landing on its own dispatch edge is not lost.
   always_comb begin
      pend_d = (pend_q & ~clr_vec) | set_vec;
   end

   // Sticky pending register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pend_q <= '0;
      end else begin
         pend_d_check: pend_q <= pend_d;
      end
   end

   // Dispatch FSM state register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Dispatch FSM next-state: offer, wait for ready, then a mandatory bubble before re-evaluating PEND.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!CLR_ALL && (pend_q != '0)) begin
               state_d = S_OFFER;
            end
         end
         S_OFFER: begin
            if (CLR_ALL) begin
               state_d = S_IDLE;
            end else if (RDY) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ID is frozen at offer start so later higher-priority events cannot disturb it.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         id_q <= '0;
      end else if (load_id) begin
         id_q <= first_idx;
      end
   end

   // Outputs decode registered state only, so REQ/ANY/ID are glitch-free.
   always_comb begin
      PEND = pend_q;
      ANY  = |pend_q;
      REQ  = (state_q == S_OFFER);
      ID   = id_q;
   end

endmodule

// File: doc/or5_event_resolver.md
Name: or5_event_resolver

Overview:
- Receiving end of a 5-input OR event aggregation.
- Where the OR gate collapses five event lines into one flag, this block latches each source edge as a sticky pending bit and drives the aggregate flag (ANY) from those bits.
- Resolves pending sources one at a time by fixed priority, through a valid/ready dispatch handshake to a downstream handler (interrupt/exception logic on the ECP5 fabric).

Parameters:
- N_SRC, 5, number of event sources (2..16).
- ID_W, 3, width of ID; must satisfy 2**ID_W >= N_SRC.
- EDGE, 1, 1 = rising-edge capture of SRC; 0 = level capture (pending re-sets every cycle SRC is high).

Ports:
- CLK  in  1  single clock, all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- SRC  in  N_SRC  event inputs, synchronous to CLK.
- MASK  in  N_SRC  1 = source enabled; masked sources never set pending.
- CLR_ALL  in  1  synchronous clear of all pending bits and abort of any offer.
- PEND  out  N_SRC  registered sticky pending bits.
- ANY  out  1  OR-reduction of PEND.
- REQ  out  1  dispatch valid.
- ID  out  ID_W  index of offered source, valid while REQ=1.
- RDY  in  1  dispatch ready from handler.

Behaviour:
Reset:
- RSTN low asynchronously forces src_q=0, PEND=0, ANY=0, REQ=0, ID=0, FSM=IDLE.
- Release is sampled on the first CLK rise with RSTN high.
- Reset mid-offer drops REQ immediately and loses all pending events.

Capture:
- EDGE=1: set_vec = SRC & ~src_q & MASK, where src_q is SRC registered every cycle.
- EDGE=0: set_vec = SRC & MASK.
- PEND_next = (PEND & ~clr_vec) | set_vec, so a new event always wins over a same-cycle clear of that bit.
- Latency: SRC[i] rising before edge k gives PEND[i]=1 and ANY=1 after edge k.

ANY:
- Combinational OR of the PEND register.
- Glitch-free relative to CLK; no extra latency.

Dispatch FSM:
- IDLE:
  - If PEND != 0 and CLR_ALL=0, go to OFFER.
  - In that transition, register ID = lowest index i with PEND[i]=1 (index 0 has highest priority) and set REQ=1.
  - REQ is therefore first high after edge k+1 for an event captured at edge k.
- OFFER:
  - REQ=1; ID held stable regardless of new higher-priority events or MASK changes.
  - Transfer occurs at the edge where REQ=1 and RDY=1. At that edge: clr_vec = onehot(ID), REQ=0, go to WAIT.
  - RDY low: hold.
- WAIT:
  - One mandatory bubble cycle with REQ=0, then go to IDLE.
  - Guarantees REQ is low for at least one cycle between offers, so PEND is re-evaluated.
  - Back-to-back throughput is one dispatch per 3 cycles.
- CLR_ALL=1 in any state:
  - clr_vec = all ones; only that cycle's set_vec survives.
  - REQ=0 after the edge; FSM goes to IDLE.
  - CLR_ALL outranks a same-cycle RDY: no transfer counted.
- Edge case: if MASK clears a bit after it is already pending, that bit stays pending and is still dispatched.
- Edge case: RDY while REQ=0 is ignored.
- Edge case: a repeat event on a bit already pending is absorbed, with no count kept.
- Edge case: with EDGE=1, SRC held high produces exactly one event.

Test Plan:
- Reset/idle:
  - Stimulus: RSTN=0 mid-cycle with REQ=1.
  - Response: REQ, ANY, PEND=0 before the next CLK edge; after release with SRC=0, everything stays 0.
- Single event latency:
  - Stimulus: MASK=5'b11111; SRC[3] pulses high for 1 cycle before edge k; RDY=1.
  - Response: PEND=5'b01000 and ANY=1 after edge k; REQ=1 with ID=3 after k+1; PEND=0 and REQ=0 after k+2; ANY=0 after k+2.
- Priority and stability:
  - Stimulus: SRC[4] and SRC[2] rise together; RDY=0 for 4 cycles; SRC[0] rises during the offer; then RDY=1.
  - Response: ID=2 held throughout; dispatch order is 2, 0, 4, each followed by a REQ=0 bubble.
- Set/clear collision:
  - Stimulus: while offering ID=1, SRC[1] rises again in the same cycle as RDY=1.
  - Response: PEND[1] remains 1 and is re-offered as ID=1 after the bubble.
- Mask and CLR_ALL:
  - Stimulus: MASK=5'b11110; SRC[0] rises.
  - Response: PEND stays 0.
  - Stimulus: with PEND=5'b10110 and REQ=1, assert CLR_ALL with RDY=1.
  - Response: PEND=0, REQ=0, no transfer.
  - Stimulus: SRC[4] rises in that same cycle.
  - Response: PEND=5'b10000.
- Level mode (EDGE=0):
  - Stimulus: SRC[1] held high; RDY=1.
  - Response: ID=1 dispatched every 3 cycles continuously; ANY stays 1.
